// File: rtl/rx_cmd_sequencer_pkg.sv
// Shared definitions for the RF command sequencer: FSM state encoding,
// default timing constants and the 16-bit command type.
package rx_cmd_sequencer_pkg;

    // 1 ms inter-byte timeout at 5 MHz
    localparam int DEF_TIMEOUT_CYC = 5000;
    // 100 ms command-starvation watchdog at 5 MHz
    localparam int DEF_WDOG_CYC    = 500000;
    // Command forced out on a watchdog trip (motor stop)
    localparam logic [15:0] DEF_SAFE_CMD = 16'h0000;

    typedef logic [15:0] cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,  // waiting for the high byte
        ST_WAIT_LO = 2'd1,  // waiting for the low byte
        ST_PRESENT = 2'd2   // command offered to the PWM block
    } state_t;

    // Commands travel high byte first.
    function automatic cmd_t pack_cmd(input logic [7:0] hi, input logic [7:0] lo);
        return {hi, lo};
    endfunction

endpackage

// File: rtl/cmd_watchdog.sv
// Command-starvation watchdog: counts every cycle since the last restart
// and raises a sticky pending flag once WDOG_CYC cycles have elapsed.
module cmd_watchdog
    import rx_cmd_sequencer_pkg::*;
#(
    parameter int WDOG_CYC = DEF_WDOG_CYC
) (
    input  logic clk_in,
    input  logic n_rst,
    input  logic restart,
    output logic pending
);

    localparam int CW = $clog2(WDOG_CYC + 1);

    logic [CW-1:0] cnt_q;
    logic          pend_q;

    // Count up until the period is reached, then hold with pending set until restarted.
    always_ff @(posedge clk_in) begin
        if (!n_rst) begin
            cnt_q  <= '0;
            pend_q <= 1'b0;
        end else if (restart) begin
            cnt_q  <= '0;
            pend_q <= 1'b0;
        end else if (!pend_q) begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CW'(WDOG_CYC - 1)) begin
                pend_q <= 1'b1;
            end
        end
    end

    assign pending = pend_q;

endmodule

// File: rtl/rx_cmd_sequencer.sv
// Assembles two received RF bytes into a 16-bit motor command and hands it
// to the PWM block. Drops half-received frames after an inter-byte timeout
// and counts them. With RX_CMD_WDOG_EN defined, a starvation watchdog forces
// SAFE_CMD out when no command has been delivered for WDOG_CYC cycles.
//
// Handshakes (rx_* and cmd_*): a transfer happens on a rising clk_in edge
// where valid and ready are both high; the source keeps data stable and
// valid asserted until that edge.
module rx_cmd_sequencer
    import rx_cmd_sequencer_pkg::*;
#(
    parameter int          TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    parameter int          WDOG_CYC    = DEF_WDOG_CYC,
    parameter logic [15:0] SAFE_CMD    = DEF_SAFE_CMD
) (
    input  logic        clk_in,
    input  logic        n_rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [15:0] cmd_data,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [7:0]  frame_err_cnt,
    output logic        wdog_trip,
    output logic [1:0]  state_dbg
);

    // Counter only needs to reach TIMEOUT_CYC-1 before expiry fires.
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    state_t        state_q, state_d;
    logic          alive_q;
    logic [7:0]    hi_q;
    cmd_t          cmd_q;
    logic [TW-1:0] tmo_q;
    logic [7:0]    err_q;
    logic          rx_acc;
    logic          cmd_hs;
    logic          tmo_expire;
    logic          trip_req;

    assign rx_acc = rx_valid && rx_ready;
    assign cmd_hs = cmd_valid && cmd_ready;

    // alive_q keeps rx_ready low until the first edge after reset release;
    // a pending watchdog trip blocks byte intake while in IDLE.
    assign rx_ready  = alive_q && ((state_q == ST_WAIT_LO) ||
                                   ((state_q == ST_IDLE) && !trip_req));
    assign cmd_valid = (state_q == ST_PRESENT);
    assign cmd_data  = cmd_q;
    assign frame_err_cnt = err_q;
    assign state_dbg = state_q;

    // State register.
    always_ff @(posedge clk_in) begin
        if (!n_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a byte on the expiry cycle wins over the timeout.
    always_comb begin
        state_d    = state_q;
        tmo_expire = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (trip_req) begin
                    state_d = ST_PRESENT;
                end else if (rx_acc) begin
                    state_d = ST_WAIT_LO;
                end
            end
            ST_WAIT_LO: begin
                if (rx_acc) begin
                    state_d = ST_PRESENT;
                end else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
                    state_d    = ST_IDLE;
                    tmo_expire = 1'b1;
                end
            end
            ST_PRESENT: begin
                if (cmd_hs) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Byte latches, inter-byte timeout counter and saturating error counter.
    always_ff @(posedge clk_in) begin
        if (!n_rst) begin
            alive_q <= 1'b0;
            hi_q    <= '0;
            cmd_q   <= '0;
            tmo_q   <= '0;
            err_q   <= '0;
        end else begin
            alive_q <= 1'b1;
            if ((state_q == ST_IDLE) && rx_acc) begin
                hi_q  <= rx_data;
                tmo_q <= '0;
            end
            if ((state_q == ST_WAIT_LO) && !rx_acc && !tmo_expire) begin
                tmo_q <= tmo_q + 1'b1;
            end
            if ((state_q == ST_WAIT_LO) && rx_acc) begin
                cmd_q <= pack_cmd(hi_q, rx_data);
            end
`ifdef RX_CMD_WDOG_EN
            if ((state_q == ST_IDLE) && trip_req) begin
                cmd_q <= SAFE_CMD;
            end
`endif
            if (tmo_expire && (err_q != 8'hFF)) begin
                err_q <= err_q + 8'd1;
            end
        end
    end

`ifdef RX_CMD_WDOG_EN
    logic wdog_pend;
    logic safe_q;
    logic trip_q;

    // Every delivered command, safe or normal, restarts the starvation period.
    cmd_watchdog #(
        .WDOG_CYC(WDOG_CYC)
    ) u_wdog (
        .clk_in (clk_in),
        .n_rst  (n_rst),
        .restart(cmd_hs),
        .pending(wdog_pend)
    );

    assign trip_req = alive_q && wdog_pend;

    // Track whether the presented command is the safe stop; wdog_trip follows it on handshake.
    always_ff @(posedge clk_in) begin
        if (!n_rst) begin
            safe_q <= 1'b0;
            trip_q <= 1'b0;
        end else begin
            if ((state_q == ST_IDLE) && trip_req) begin
                safe_q <= 1'b1;
            end else if ((state_q == ST_WAIT_LO) && rx_acc) begin
                safe_q <= 1'b0;
            end
            if (cmd_hs) begin
                trip_q <= safe_q;
            end
        end
    end

    assign wdog_trip = trip_q;
`else
    logic wdog_unused;

    assign trip_req    = 1'b0;
    assign wdog_trip   = 1'b0;
    assign wdog_unused = ^{SAFE_CMD, WDOG_CYC};
`endif

endmodule

// File: tb/tb_rx_cmd_sequencer.sv
// Self-checking bench for rx_cmd_sequencer: directed scenarios plus random
// framed traffic scored against an expected-command queue.
module tb_rx_cmd_sequencer;
    import rx_cmd_sequencer_pkg::*;

    localparam int TMO = 20;
    localparam int WDG = 300;
    localparam int W   = 17;   // {is_safe, cmd}

    logic        clk_in = 1'b0;
    logic        n_rst = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [15:0] cmd_data;
    logic        cmd_valid;
    logic        cmd_ready = 1'b1;
    logic [7:0]  frame_err_cnt;
    logic        wdog_trip;
    logic [1:0]  state_dbg;

    int checks = 0;
    int failures = 0;
    logic [W-1:0] exp_q[$];
    logic exp_trip = 1'b0;
    int   exp_err = 0;
    int   rdy_mode = 0;   // 0: ready high, 1: random, 2: ready low

    rx_cmd_sequencer #(
        .TIMEOUT_CYC(TMO),
        .WDOG_CYC   (WDG)
    ) dut (
        .clk_in       (clk_in),
        .n_rst        (n_rst),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .cmd_data     (cmd_data),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .frame_err_cnt(frame_err_cnt),
        .wdog_trip    (wdog_trip),
        .state_dbg    (state_dbg)
    );

    // Clock and reset
    initial forever #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic align();
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        align();
        n_rst = 1'b0;
        rx_valid = 1'b0;
        exp_q.delete();
        exp_trip = 1'b0;
        exp_err = 0;
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        chk("rst_rx_ready", rx_ready, 0);
        chk("rst_cmd_valid", cmd_valid, 0);
        chk("rst_cmd_data", cmd_data, 0);
        chk("rst_err_cnt", frame_err_cnt, 0);
        chk("rst_wdog_trip", wdog_trip, 0);
        chk("rst_state", state_dbg, 32'(ST_IDLE));
        align();
        n_rst = 1'b1;
        @(negedge clk_in);
        chk("rel_rx_ready_low", rx_ready, 0);
        align();
        @(negedge clk_in);
        chk("rel_rx_ready_high", rx_ready, 1);
        align();
    endtask

    // Driver tasks: called at posedge+1, return at posedge+1 after the accepting edge.
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        rx_data = b;
        rx_valid = 1'b1;
        @(negedge clk_in);
        while (!rx_ready && n < 200) begin
            n++;
            @(negedge clk_in);
        end
        chk("accept_bound", (n < 200), 1);
        align();
        rx_valid = 1'b0;
    endtask

    // High byte, gap idle cycles, then low byte unless the gap reaches the timeout.
    task automatic frame(input logic [7:0] hi, input logic [7:0] lo, input int gap);
        send_byte(hi);
        repeat (gap) @(posedge clk_in);
        #1;
        if (gap >= TMO) begin
            if (exp_err < 255) exp_err++;
        end else begin
            exp_q.push_back({1'b0, hi, lo});
            send_byte(lo);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clk_in);
            n++;
        end
        chk("drain_empty", exp_q.size(), 0);
        align();
    endtask

    // Ready driver
    initial forever begin
        @(posedge clk_in);
        #2;
        if (rdy_mode == 0) cmd_ready = 1'b1;
        else if (rdy_mode == 1) cmd_ready = ($urandom_range(0, 3) != 0);
        else cmd_ready = 1'b0;
    end

    // Scoreboard: pops one expected command per output handshake.
    initial begin
        logic        prev_stall;
        logic [15:0] prev_data;
        logic [W-1:0] e;
        prev_stall = 1'b0;
        prev_data = '0;
        forever begin
            @(negedge clk_in);
            if (n_rst) begin
                chk("wdog_trip", wdog_trip, exp_trip);
                if (prev_stall) chk("hold_data", cmd_data, prev_data);
                if (cmd_valid && cmd_ready) begin
                    chk("cmd_expected", (exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk("cmd_data", cmd_data, e[15:0]);
                        exp_trip = e[16];
                    end
                end
                prev_stall = cmd_valid && !cmd_ready;
                prev_data = cmd_data;
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    initial begin
        int n;
        logic seen;
        do_reset();

        // Back-to-back pair: valid for exactly one cycle right after the low accept
        frame(8'hA5, 8'h3C, 0);
        @(negedge clk_in);
        chk("b2b_valid_on", cmd_valid, 1);
        chk("b2b_data", cmd_data, 16'hA53C);
        @(negedge clk_in);
        chk("b2b_valid_off", cmd_valid, 0);
        align();
        chk("b2b_state_idle", state_dbg, 32'(ST_IDLE));

        // Timeout drops the high byte and counts one error
        frame(8'h11, 8'h00, TMO);
        chk("tmo_err_cnt", frame_err_cnt, 1);
        chk("tmo_state_idle", state_dbg, 32'(ST_IDLE));
        frame(8'h22, 8'h33, 0);
        drain();

        // Low byte on the exact expiry cycle still wins
        frame(8'h66, 8'h77, TMO - 1);
        drain();
        chk("edge_err_cnt", frame_err_cnt, 1);

        // Back-pressure: data holds, no byte intake
        rdy_mode = 2;
        align();
        align();
        frame(8'hC3, 8'h5A, 0);
        rx_data = 8'h77;
        rx_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_in);
            chk("stall_valid", cmd_valid, 1);
            chk("stall_data", cmd_data, 16'hC35A);
            chk("stall_rx_ready", rx_ready, 0);
        end
        align();
        rx_valid = 1'b0;
        rdy_mode = 0;
        drain();
        frame(8'h44, 8'h55, 0);
        drain();

        // Random framed traffic with random back-pressure
        rdy_mode = 1;
        for (int i = 0; i < 40; i++) begin
            int g;
            if ($urandom_range(0, 4) == 0) g = TMO + $urandom_range(0, 5);
            else g = $urandom_range(0, TMO - 1);
            frame(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), g);
        end
        rdy_mode = 0;
        drain();
        chk("rand_err_cnt", frame_err_cnt, exp_err);

        // Error counter saturation (good frame every 10 timeouts keeps the watchdog quiet)
        for (int r = 0; r < 26; r++) begin
            for (int t = 0; t < 10; t++) frame(8'(r), 8'(t), TMO);
            frame(8'hAB, 8'(r), 0);
            drain();
        end
        chk("sat_err_cnt", frame_err_cnt, exp_err);
        chk("sat_model_255", exp_err, 255);

        // Reset mid-frame drops the partial command
        send_byte(8'hFF);
        do_reset();
        frame(8'h10, 8'h20, 0);
        drain();
        chk("post_rst_err_cnt", frame_err_cnt, 0);

`ifdef RX_CMD_WDOG_EN
        // Starvation issues SAFE_CMD, then again after another period
        do_reset();
        for (int k = 0; k < 2; k++) begin
            exp_q.push_back({1'b1, DEF_SAFE_CMD});
            n = 0;
            while (!cmd_valid && n < WDG + 50) begin
                @(negedge clk_in);
                n++;
            end
            chk("wdog_period", ((n >= WDG - 8) && (n <= WDG + 3)), 1);
            chk("wdog_safe_data", cmd_data, DEF_SAFE_CMD);
            drain();
            chk("wdog_trip_set", wdog_trip, 1);
        end
        frame(8'h01, 8'h02, 0);
        drain();
        chk("wdog_trip_clear", wdog_trip, 0);
`else
        do_reset();
        seen = 1'b0;
        repeat (WDG + 20) begin
            @(negedge clk_in);
            if (cmd_valid) seen = 1'b1;
        end
        chk("no_wdog_cmd", seen, 0);
        chk("no_wdog_trip", wdog_trip, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rx_cmd_sequencer.md
RX_CMD_SEQUENCER -- requirements
Module: rx_cmd_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 5000, meaning the inter-byte timeout in clk_in cycles (1 ms at 5 MHz).
REQ-002 SHALL have parameter WDOG_CYC, default 500000, meaning the command-starvation watchdog period in clk_in cycles (100 ms).
REQ-003 SHALL have parameter SAFE_CMD, default 16'h0000, meaning the command issued on watchdog trip (motor stop).
REQ-004 SHALL have port clk_in, input, 1, the single clock (5 MHz domain).
REQ-005 SHALL have port n_rst, input, 1, synchronous active-low reset.
REQ-006 SHALL have port rx_data, input, 8, the received RF byte.
REQ-007 SHALL have port rx_valid, input, 1, rx_data valid.
REQ-008 SHALL have port rx_ready, output, 1, byte accepted when rx_valid && rx_ready.
REQ-009 SHALL have port cmd_data, output, 16, the assembled command {high byte, low byte}.
REQ-010 SHALL have port cmd_valid, output, 1, cmd_data valid toward the PWM block.
REQ-011 SHALL have port cmd_ready, input, 1, PWM accepts when cmd_valid && cmd_ready.
REQ-012 SHALL have port frame_err_cnt, output, 8, saturating count of inter-byte timeouts.
REQ-013 SHALL have port wdog_trip, output, 1, high while the last issued command was SAFE_CMD from the watchdog.

Function
REQ-014 SHALL implement FSM states IDLE (await high byte), WAIT_LO (await low byte), PRESENT (drive cmd_valid).
REQ-015 SHALL assert rx_ready in IDLE and WAIT_LO only, and deassert it in PRESENT.
REQ-016 IDLE: on byte accept, SHALL latch the byte as the high byte, clear the timeout counter, and go to WAIT_LO.
REQ-017 WAIT_LO: on byte accept, SHALL latch the low byte and go to PRESENT; cmd_valid SHALL rise the next cycle (1-cycle latency).
REQ-018 WAIT_LO: if no byte is accepted within TIMEOUT_CYC cycles, SHALL discard the high byte, increment frame_err_cnt (saturating at 255), and go to IDLE.
REQ-019 If a byte accept and timeout expiry coincide, the byte SHALL win and no error SHALL be counted.
REQ-020 PRESENT: cmd_data SHALL hold stable while cmd_valid && !cmd_ready; on handshake SHALL return to IDLE; cmd_valid SHALL deassert the following cycle.
REQ-021 A normal command handshake SHALL clear wdog_trip and restart the watchdog counter.
REQ-022 The watchdog counter SHALL run in all states and SHALL set a pending trip on reaching WDOG_CYC, then hold.
REQ-023 A pending trip SHALL be served only from IDLE: present SAFE_CMD via PRESENT, set wdog_trip, and clear the pending flag and counter on handshake.
REQ-024 In IDLE, a pending trip SHALL take priority over a simultaneous rx_valid (rx_ready low that cycle).
REQ-025 The counter SHALL restart after a SAFE_CMD handshake, so continued starvation re-issues SAFE_CMD every WDOG_CYC cycles.

Reset
REQ-026 While n_rst is low at a clk_in edge, the block SHALL enter IDLE, clear all counters, latches and the pending trip, and drive cmd_valid=0, cmd_data=0, frame_err_cnt=0, wdog_trip=0, rx_ready=0 (rx_ready rises the first cycle after release).
REQ-027 Reset asserted mid-frame or mid-PRESENT SHALL drop the partial or unaccepted command without completing a handshake.

Configuration
REQ-028 Macro RX_CMD_WDOG_EN defined: watchdog per REQ-021..025.
REQ-029 Macro undefined: no watchdog logic; wdog_trip SHALL be tied 0, SAFE_CMD unused, and all other behaviour identical.

Structure
REQ-030 A shared package SHALL hold the FSM state encoding, the default constants (TIMEOUT_CYC, WDOG_CYC, SAFE_CMD) and the 16-bit command type.
REQ-031 One sub-module, cmd_watchdog (counter, pending flag, restart input), SHALL be instantiated only under RX_CMD_WDOG_EN.

Verification
REQ-032 Bytes 8'hA5 then 8'h3C back-to-back, cmd_ready=1 -> cmd_data=16'hA53C, cmd_valid high exactly 1 cycle, beginning 1 cycle after the second accept.
REQ-033 Byte 8'h11, then a gap of TIMEOUT_CYC cycles -> frame_err_cnt=1, FSM in IDLE; the next pair 8'h22,8'h33 -> cmd_data=16'h2233.
REQ-034 cmd_ready held 0 for 10 cycles after cmd_valid -> cmd_data stable, rx_ready=0 throughout, and an offered byte is not accepted.
REQ-035 Low byte arriving on the exact timeout-expiry cycle -> command issued, frame_err_cnt unchanged.
REQ-036 With RX_CMD_WDOG_EN and no input for WDOG_CYC cycles -> cmd_data=16'h0000, wdog_trip=1; a following valid pair 8'h01,8'h02 handshake -> wdog_trip=0.
REQ-037 n_rst low during WAIT_LO after byte 8'hFF -> all outputs at reset values; the next pair 8'h10,8'h20 -> cmd_data=16'h1020.
